// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - multi-channel edge detector with round-robin event serialiser
//
// Purpose:
//   Detects rising/falling edges on N_CH synchronous level inputs. Each channel
//   holds one pending rise and one pending fall. Pending edges are serialised
//   round-robin onto one registered valid/ready event port.
//
// Ports:
//   clk         clock, all logic on posedge
//   reset       asynchronous active-low reset
//   a_i         level inputs, already synchronous to clk
//   ev_ready_i  consumer accepts the event when high together with ev_valid_o
//   clr_ovf_i   synchronous clear of all ovf_o bits
//   ev_valid_o  event register holds a valid event
//   ev_id_o     channel index of the event
//   ev_rise_o   1 = rising edge, 0 = falling edge
//   ovf_o       sticky per-channel overflow flags

module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] a_i,
    input  logic            ev_ready_i,
    input  logic            clr_ovf_i,
    output logic            ev_valid_o,
    output logic [ID_W-1:0] ev_id_o,
    output logic            ev_rise_o,
    output logic [N_CH-1:0] ovf_o
);

    logic            armed;
    logic [N_CH-1:0] prev;
    logic [N_CH-1:0] pend_r;
    logic [N_CH-1:0] pend_f;
    logic [ID_W-1:0] ptr;

    logic [N_CH-1:0] rise_det;
    logic [N_CH-1:0] fall_det;
    logic [N_CH-1:0] pend_any;
    logic [N_CH-1:0] cons_r;
    logic [N_CH-1:0] cons_f;
    logic [N_CH-1:0] ovf_new;
    logic            load;
    logic            found;
    logic            grant;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_rise;
    int              idx;

    // No edges until the first sample after reset has been captured, so
    // inputs that are already high at reset never produce events.
    assign rise_det = armed ? (a_i & ~prev) : '0;
    assign fall_det = armed ? (~a_i & prev) : '0;
    assign pend_any = pend_r | pend_f;
    assign load     = ~ev_valid_o | ev_ready_i;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        found    = 1'b0;
        gnt_id   = '0;
        gnt_rise = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!found && pend_any[idx]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
                // With both flags set the older edge goes first: a low level
                // now means the last edge was a fall, so the rise is older.
                gnt_rise = pend_r[idx] & (~pend_f[idx] | ~prev[idx]);
            end
        end
    end

    assign grant = load & found;

    always_comb begin
        cons_r = '0;
        cons_f = '0;
        if (grant) begin
            if (gnt_rise) begin
                cons_r[gnt_id] = 1'b1;
            end else begin
                cons_f[gnt_id] = 1'b1;
            end
        end
    end

    // An edge landing on a flag that is consumed in the same cycle simply
    // re-arms the flag; only a still-held flag counts as an overflow.
    assign ovf_new = (rise_det & pend_r & ~cons_r) | (fall_det & pend_f & ~cons_f);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed      <= 1'b0;
            prev       <= '0;
            pend_r     <= '0;
            pend_f     <= '0;
            ptr        <= ID_W'(N_CH - 1);
            ev_valid_o <= 1'b0;
            ev_id_o    <= '0;
            ev_rise_o  <= 1'b0;
            ovf_o      <= '0;
        end else begin
            armed  <= 1'b1;
            prev   <= a_i;
            pend_r <= (pend_r & ~cons_r) | rise_det;
            pend_f <= (pend_f & ~cons_f) | fall_det;
            ovf_o  <= (clr_ovf_i ? '0 : ovf_o) | ovf_new;
            if (load) begin
                if (found) begin
                    ev_valid_o <= 1'b1;
                    ev_id_o    <= gnt_id;
                    ev_rise_o  <= gnt_rise;
                    ptr        <= gnt_id;
                end else begin
                    ev_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - self-checking bench for edge_event_arbiter

module tb_edge_event_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] a_i = '0;
    logic         ev_ready_i = 1'b0;
    logic         clr_ovf_i = 1'b0;
    logic         ev_valid_o;
    logic [1:0]   ev_id_o;
    logic         ev_rise_o;
    logic [N-1:0] ovf_o;

    edge_event_arbiter #(.N_CH(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_i        (a_i),
        .ev_ready_i (ev_ready_i),
        .clr_ovf_i  (clr_ovf_i),
        .ev_valid_o (ev_valid_o),
        .ev_id_o    (ev_id_o),
        .ev_rise_o  (ev_rise_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel keeps an ordered list of outstanding edge
    // types (oldest first, at most one of each type). A repeated type is an
    // overflow: it is merged and becomes the newest entry.
    bit         m_armed;
    bit [N-1:0] m_prev;
    bit         qe[N][2];
    int         qn[N];
    int         m_ptr;
    bit         m_valid;
    int         m_id;
    bit         m_rise;
    bit [N-1:0] m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0;
        m_prev  = '0;
        for (int c = 0; c < N; c++) qn[c] = 0;
        m_ptr   = N - 1;
        m_valid = 0;
        m_id    = 0;
        m_rise  = 0;
        m_ovf   = '0;
    endtask

    task automatic model_step(input bit [N-1:0] a, input bit rdy, input bit clr);
        bit         found;
        bit [N-1:0] nov;
        int         c;
        bit         t;
        if (!m_valid || rdy) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && qn[c] > 0) begin
                    found    = 1;
                    m_id     = c;
                    m_rise   = qe[c][0];
                    m_ptr    = c;
                    qe[c][0] = qe[c][1];
                    qn[c]    = qn[c] - 1;
                end
            end
            m_valid = found;
        end
        nov = '0;
        if (m_armed) begin
            for (int ch = 0; ch < N; ch++) begin
                if (a[ch] != m_prev[ch]) begin
                    t = a[ch];
                    if (qn[ch] > 0 && qe[ch][0] == t) begin
                        nov[ch]   = 1;
                        qe[ch][0] = qe[ch][1];
                        qn[ch]    = qn[ch] - 1;
                    end else if (qn[ch] > 1 && qe[ch][1] == t) begin
                        nov[ch] = 1;
                        qn[ch]  = qn[ch] - 1;
                    end
                    qe[ch][qn[ch]] = t;
                    qn[ch] = qn[ch] + 1;
                end
            end
        end
        m_ovf   = (clr ? '0 : m_ovf) | nov;
        m_prev  = a;
        m_armed = 1;
    endtask

    task automatic compare_model();
        check_eq("valid", ev_valid_o, m_valid);
        if (m_valid) begin
            check_eq("id", ev_id_o, m_id);
            check_eq("rise", ev_rise_o, m_rise);
        end
        check_eq("ovf", ovf_o, m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(a_i, ev_ready_i, clr_ovf_i);
        #1;
        compare_model();
    endtask

    task automatic step(input logic [N-1:0] a, input logic rdy, input logic clr);
        @(negedge clk);
        a_i        = a;
        ev_ready_i = rdy;
        clr_ovf_i  = clr;
        tick();
    endtask

    // Assert reset at a falling edge, check the cleared outputs, release and
    // let the arming edge sample a.
    task automatic do_reset(input logic [N-1:0] a);
        @(negedge clk);
        a_i        = a;
        ev_ready_i = 1'b1;
        clr_ovf_i  = 1'b0;
        reset      = 1'b0;
        model_reset();
        #1;
        check_eq("rst_valid", ev_valid_o, 0);
        check_eq("rst_id", ev_id_o, 0);
        check_eq("rst_rise", ev_rise_o, 0);
        check_eq("rst_ovf", ovf_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Inputs high through reset never produce events.
        do_reset(4'b1111);
        repeat (5) step(4'b1111, 1'b1, 1'b0);
        check_eq("t1_valid", ev_valid_o, 0);
        check_eq("t1_ovf", ovf_o, 0);

        // Single rise, two-edge latency, valid drops after acceptance.
        do_reset(4'b0000);
        step(4'b0100, 1'b1, 1'b0);
        check_eq("t2_k_valid", ev_valid_o, 0);
        step(4'b0100, 1'b1, 1'b0);
        check_eq("t2_valid", ev_valid_o, 1);
        check_eq("t2_id", ev_id_o, 2);
        check_eq("t2_rise", ev_rise_o, 1);
        step(4'b0100, 1'b1, 1'b0);
        check_eq("t2_drop", ev_valid_o, 0);

        // Three simultaneous rises, then falls with pointer wrap.
        do_reset(4'b0000);
        step(4'b1011, 1'b1, 1'b0);
        step(4'b1011, 1'b1, 1'b0);
        check_eq("t3_id_a", ev_id_o, 0);
        step(4'b1011, 1'b1, 1'b0);
        check_eq("t3_id_b", ev_id_o, 1);
        step(4'b1011, 1'b1, 1'b0);
        check_eq("t3_id_c", ev_id_o, 3);
        check_eq("t3_rise_c", ev_rise_o, 1);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        check_eq("t3_fall_id_a", ev_id_o, 0);
        check_eq("t3_fall_rise_a", ev_rise_o, 0);
        step(4'b0010, 1'b1, 1'b0);
        check_eq("t3_fall_id_b", ev_id_o, 3);
        check_eq("t3_fall_rise_b", ev_rise_o, 0);

        // Stall holds the event; rise then fall delivered in order.
        do_reset(4'b0000);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("t4_valid", ev_valid_o, 1);
        check_eq("t4_id", ev_id_o, 1);
        check_eq("t4_rise", ev_rise_o, 1);
        repeat (2) step(4'b0000, 1'b0, 1'b0);
        check_eq("t4_hold_id", ev_id_o, 1);
        check_eq("t4_hold_rise", ev_rise_o, 1);
        step(4'b0000, 1'b1, 1'b0);
        check_eq("t4_fall_valid", ev_valid_o, 1);
        check_eq("t4_fall_rise", ev_rise_o, 0);
        step(4'b0000, 1'b1, 1'b0);
        check_eq("t4_end_valid", ev_valid_o, 0);

        // Overflow under stall and clear.
        do_reset(4'b0000);
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
        check_eq("t5_ovf", ovf_o, 4'b0001);
        step(4'b0000, 1'b0, 1'b1);
        check_eq("t5_clr", ovf_o, 4'b0000);

        // Asynchronous reset mid-cycle with events pending.
        do_reset(4'b0000);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("t6_pre_valid", ev_valid_o, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_async_valid", ev_valid_o, 0);
        do_reset(4'b0000);
        repeat (6) step(4'b0000, 1'b1, 1'b0);
        check_eq("t6_no_stale", ev_valid_o, 0);

        // Randomised traffic against the model.
        do_reset(4'($urandom));
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] na;
            na = a_i;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) na[b] = ~na[b];
            end
            if ($urandom_range(199) == 0) begin
                do_reset(na);
            end else begin
                step(na, ($urandom_range(9) < 6), ($urandom_range(15) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
